// File: rtl/csa_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_acc_pkg
//  Description : Shared types, default widths and helpers for the carry-save
//                frame accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_acc_pkg;

    // Default operand, accumulator and operand-count widths
    localparam int c_data_w = 4;
    localparam int c_acc_w  = 8;
    localparam int c_cnt_w  = 8;

    // Frame controller states
    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // Saturating increment for a counter of 'width' bits (width < 32).
    // The counter sticks at its all-ones value instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (cnt >= max_val) begin
            return max_val;
        end
        return cnt + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_compress_row.sv
`default_nettype none
// ============================================================================
//  Module      : csa_compress_row
//  Description : Combinational 3:2 compressor row. Reduces three W-bit vectors
//                to a bitwise sum and a bitwise majority (carry) vector; the
//                caller applies the carry shift. With b tied to zero the row
//                degenerates into a half-adder row.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_compress_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);

    // Per-bit full-adder sum and carry, no propagation between bit positions
    always_comb begin
        sum = a ^ b ^ c;
        maj = (a & b) | (a & c) | (b & c);
    end

endmodule
`default_nettype wire

// File: rtl/csa_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : csa_frame_accumulator
//  Description : Streaming multi-operand adder. Operands are folded into a
//                carry-save running total (S,C) one per cycle; at frame end
//                the pair is resolved iteratively into a binary sum and
//                presented on a valid/ready result port with an exact
//                overflow flag and a saturating operand count.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_frame_accumulator
    import csa_acc_pkg::*;
#(
    parameter int DATA_W = c_data_w,   // must not exceed ACC_W
    parameter int ACC_W  = c_acc_w,    // at least 2
    parameter int CNT_W  = c_cnt_w     // below 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_count
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;

    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic [CNT_W-1:0]   r_out_count;

    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_row_b;
    logic [ACC_W-1:0]   w_row_c;
    logic [ACC_W-1:0]   w_row_sum;
    logic [ACC_W-1:0]   w_row_maj;
    logic [ACC_W-1:0]   w_maj_sh;
    logic               w_maj_drop;
    logic               w_in_hs;
    logic               w_c_zero;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Operand zero-extended to the accumulator width
    assign w_x = ACC_W'(in_data);

    // One shared row: full 3:2 compression (S,C,x) while accumulating,
    // half-adder (S,0,C) while resolving the carry-save pair.
    assign w_row_b = (r_state == ST_ACCUM) ? r_c : '0;
    assign w_row_c = (r_state == ST_ACCUM) ? w_x : r_c;

    csa_compress_row #(
        .W   (ACC_W)
    ) u_row (
        .a   (r_s),
        .b   (w_row_b),
        .c   (w_row_c),
        .sum (w_row_sum),
        .maj (w_row_maj)
    );

    // Carry vector moves up one weight; the MSB carry falls off the top and
    // is exactly one lost 2^ACC_W, so it is recorded as overflow.
    assign w_maj_sh   = {w_row_maj[ACC_W-2:0], 1'b0};
    assign w_maj_drop = w_row_maj[ACC_W-1];

    assign w_in_hs   = in_valid & in_ready;
    assign w_c_zero  = (r_c == '0);
    assign w_cnt_inc = CNT_W'(sat_inc(32'(r_count), CNT_W));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (w_c_zero) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // Carry-save accumulation, resolution, and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= '0;
            r_c         <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else begin
            unique case (r_state)
                ST_ACCUM: begin
                    if (w_in_hs) begin
                        r_s     <= w_row_sum;
                        r_c     <= w_maj_sh;
                        r_ovf   <= r_ovf | w_maj_drop;
                        r_count <= w_cnt_inc;
                    end
                end
                ST_RESOLVE: begin
                    if (!w_c_zero) begin
                        r_s   <= w_row_sum;
                        r_c   <= w_maj_sh;
                        r_ovf <= r_ovf | w_maj_drop;
                    end else begin
                        r_out_sum   <= r_s;
                        r_out_ovf   <= r_ovf;
                        r_out_count <= r_count;
                    end
                end
                ST_OUTPUT: begin
                    // Result registers keep their value after consumption
                    if (out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_ovf   <= 1'b0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_s <= r_s;
                end
            endcase
        end
    end

    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_csa_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_frame_accumulator
//  Description : Self-checking bench for csa_frame_accumulator with a
//                scoreboard of expected frame results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_frame_accumulator;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 8;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   frame_q[$];
    int   checks = 0;
    int   errors = 0;

    csa_frame_accumulator #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives frame_q as one frame starting at a negedge; ends at the negedge
    // right after the last handshake. Optionally records the expected result.
    task automatic send_frame(input int gap_max, input bit record);
        int   total;
        int   wcyc;
        exp_t e;
        total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        e.sum = ACC_W'(total);
        e.ovf = (total >= 256);
        e.cnt = (frame_q.size() > 255) ? 8'd255 : CNT_W'(frame_q.size());
        if (record) sb.push_back(e);
        foreach (frame_q[i]) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = DATA_W'(frame_q[i]);
            in_last  = (i == frame_q.size() - 1);
            wcyc = 0;
            while (!in_ready && wcyc < 100) begin
                @(negedge clk);
                wcyc++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout op=%0d in_ready=%0b required 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Waits (bounded) for out_valid; lat counts negedges from the one after
    // the last input handshake, so lat = 1 + resolve iterations.
    task automatic collect(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic release_out(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_sum !== 8'd0 || out_ovf !== 1'b0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs sum=%0d ovf=%0b cnt=%0d required 0/0/0", out_sum, out_ovf, out_count);
        end
    endtask

    task automatic test_three_15();
        int lat; bit ok; exp_t e;
        frame_q = '{15, 15, 15};
        send_frame(0, 1'b1);
        collect(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || lat > 9 || lat < 1) begin
            errors++;
            $display("FAIL three15_latency lat=%0d valid=%0b required 1..9", lat, ok);
        end
        checks++;
        if (out_sum !== e.sum || out_ovf !== e.ovf || out_count !== e.cnt) begin
            errors++;
            $display("FAIL three15_result sum=%0d ovf=%0b cnt=%0d required %0d/%0b/%0d",
                     out_sum, out_ovf, out_count, e.sum, e.ovf, e.cnt);
        end
        release_out(0);
    endtask

    task automatic test_single();
        int lat; bit ok; exp_t e;
        frame_q = '{9};
        send_frame(0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_resolve_state out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
        end
        collect(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || lat != 1) begin
            errors++;
            $display("FAIL single_latency lat=%0d required 1", lat);
        end
        checks++;
        if (out_sum !== e.sum || out_ovf !== e.ovf || out_count !== e.cnt) begin
            errors++;
            $display("FAIL single_result sum=%0d ovf=%0b cnt=%0d required %0d/%0b/%0d",
                     out_sum, out_ovf, out_count, e.sum, e.ovf, e.cnt);
        end
        release_out(1);
    endtask

    task automatic test_overflow(input int n, input int val, input string name);
        int lat; bit ok; exp_t e;
        frame_q.delete();
        repeat (n) frame_q.push_back(val);
        send_frame(0, 1'b1);
        collect(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || out_sum !== e.sum || out_ovf !== e.ovf || out_count !== e.cnt) begin
            errors++;
            $display("FAIL %s sum=%0d ovf=%0b cnt=%0d valid=%0b required %0d/%0b/%0d",
                     name, out_sum, out_ovf, out_count, ok, e.sum, e.ovf, e.cnt);
        end
        release_out(0);
    endtask

    task automatic test_backpressure();
        int lat; bit ok; exp_t e; int bad;
        frame_q = '{7, 8, 13};
        send_frame(1, 1'b1);
        collect(lat, ok);
        e = sb.pop_front();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            // Inputs are offered while busy and must be ignored
            in_valid = 1'b1;
            in_data  = 4'd5;
            in_last  = 1'b1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e.sum ||
                out_ovf !== e.ovf || out_count !== e.cnt) bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold bad_cycles=%0d sum=%0d cnt=%0d required 0 and %0d/%0d",
                     bad, out_sum, out_count, e.sum, e.cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_bypass in_ready=%0b required 0", in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_resolve();
        int lat; bit ok; exp_t e;
        frame_q = '{15, 15, 15};
        send_frame(0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_resolve in_ready=%0b out_valid=%0b required 0/0", in_ready, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_sum !== 8'd0 || out_ovf !== 1'b0 || out_count !== 8'd0 ||
            out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_outputs sum=%0d ovf=%0b cnt=%0d valid=%0b ready=%0b required 0/0/0/0/1",
                     out_sum, out_ovf, out_count, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame_q = '{1, 2};
        send_frame(0, 1'b1);
        collect(lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || out_sum !== e.sum || out_ovf !== e.ovf || out_count !== e.cnt) begin
            errors++;
            $display("FAIL midrst_next_frame sum=%0d ovf=%0b cnt=%0d required %0d/%0b/%0d",
                     out_sum, out_ovf, out_count, e.sum, e.ovf, e.cnt);
        end
        release_out(0);
    endtask

    task automatic test_random();
        int lat; bit ok; exp_t e; int len;
        for (int f = 0; f < 30; f++) begin
            frame_q.delete();
            len = $urandom_range(40, 1);
            for (int j = 0; j < len; j++) frame_q.push_back($urandom_range(15, 0));
            send_frame(2, 1'b1);
            collect(lat, ok);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL random_scoreboard_empty frame=%0d", f);
            end else begin
                e = sb.pop_front();
                if (!ok || lat > 9 || out_sum !== e.sum || out_ovf !== e.ovf || out_count !== e.cnt) begin
                    errors++;
                    $display("FAIL random_frame%0d sum=%0d ovf=%0b cnt=%0d lat=%0d required %0d/%0b/%0d",
                             f, out_sum, out_ovf, out_count, lat, e.sum, e.ovf, e.cnt);
                end
            end
            release_out($urandom_range(4, 0));
        end
    endtask

    initial begin
        test_reset();
        test_three_15();
        test_single();
        test_overflow(20, 15, "twenty_15");
        test_overflow(300, 1, "count_saturate");
        test_backpressure();
        test_reset_mid_resolve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
